fetch_stage: RTL

Instruction fetch stage feeding the decode/control-logic stage of the MIPS datapath. It holds the PC and issues single-outstanding requests to instruction memory. Returned words are buffered in an IF/ID register with valid/ready backpressure, and `id_opcode` is presented to the control decoder. Branch redirects from execute and jump redirects from decode flush in-flight work and restart fetch at the target.

---
 rtl/fetch_stage_pkg.sv | 31 +++
 rtl/fetch_stage_if_id_reg.sv | 98 +++++++++
 rtl/fetch_stage.sv | 104 ++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared definitions for the instruction fetch stage and the
// control decoder.
//   - fetch_state_e : fetch FSM state encodings
//   - DEF_RESET_PC / DEF_NOP_INSTR : parameter defaults
//   - OP_* : primary opcode constants (instr[31:26])
//   - jump_target() : J-type target from PC+4 and the instruction word
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [31:0] instr);
    return {pc4[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with a 1-entry skid buffer.
//   clk, rst_n     : clock, synchronous active-low reset
//   flush          : drop both the IF/ID entry and the skid entry
//   load           : a fetched word arrives (load_instr / load_pc4)
//   out_ready      : consumer accepts on out_valid && out_ready
//   out_valid, out_instr, out_pc4 : registered IF/ID contents
// A load lands in the main register when it is empty or being taken this
// cycle, otherwise in the skid. The skid refills the main register when the
// consumer takes it.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc4,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc4
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic        take;

  assign take = valid_q && out_ready;

  always_comb begin
    valid_d      = valid_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    skid_vld_d   = skid_vld_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    if (flush) begin
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
      skid_vld_d = 1'b0;
    end else begin
      if (take) begin
        if (skid_vld_q) begin
          valid_d    = 1'b1;
          instr_d    = skid_instr_q;
          pc4_d      = skid_pc4_q;
          skid_vld_d = 1'b0;
        end else begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end
      end
      // The fetch FSM never loads while the skid is occupied, so a load
      // cannot collide with the skid refill above.
      if (load) begin
        if (!valid_q || take) begin
          valid_d = 1'b1;
          instr_d = load_instr;
          pc4_d   = load_pc4;
        end else begin
          skid_vld_d   = 1'b1;
          skid_instr_d = load_instr;
          skid_pc4_d   = load_pc4;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      instr_q      <= NOP_INSTR;
      pc4_q        <= 32'h0;
      skid_vld_q   <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc4_q   <= 32'h0;
    end else begin
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      skid_vld_q   <= skid_vld_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_pc4   = pc4_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction fetch with single-outstanding imem requests.
//   clk, rst_n                 : clock, synchronous active-low reset
//   imem_req/addr/gnt          : request channel (addr = PC)
//   imem_rvalid/rdata          : response channel, no backpressure
//   id_valid/ready/instr/pc4   : IF/ID output with valid/ready handshake
//   id_opcode                  : id_instr[31:26] to the control decoder
//   jump                       : decoder jump, honoured on an id handshake
//   br_taken/br_target         : taken branch redirect from execute
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [5:0]  id_opcode,
  output logic [31:0] id_pc4,
  input  logic        jump,
  input  logic        br_taken,
  input  logic [31:0] br_target
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_pc4_q, pend_pc4_d;
  logic         hs, jump_fire, redirect, accept, load, outstanding;
  logic [31:0]  target;

  assign hs        = id_valid && id_ready;
  assign jump_fire = jump && hs;
  // Branch is the older instruction, so it wins over a same-cycle jump.
  assign redirect  = br_taken || jump_fire;
  assign target    = br_taken ? br_target : jump_target(id_pc4, id_instr);
  assign accept    = !id_valid || hs;
  assign load      = (state_q == S_WAIT) && imem_rvalid && !redirect;

  // A request is still in flight after this edge if it was just granted or
  // its response has not yet come back.
  assign outstanding = ((state_q == S_REQ) && imem_gnt) ||
                       (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !imem_rvalid);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc4_d = pend_pc4_q;
    unique case (state_q)
      S_REQ:   if (imem_gnt) begin
                 pc_d       = pc_q + 32'd4;
                 pend_pc4_d = pc_q + 32'd4;
                 state_d    = S_WAIT;
               end
      S_WAIT:  if (imem_rvalid) state_d = accept ? S_REQ : S_HOLD;
      S_HOLD:  if (hs) state_d = S_REQ;
      S_DRAIN: if (imem_rvalid) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
    // A redirect in DRAIN that coincides with the squashed response leaves
    // nothing in flight, so it restarts fetch instead of draining again.
    if (redirect) begin
      pc_d    = target & ~32'h3;
      state_d = outstanding ? S_DRAIN : S_REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      pend_pc4_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc4_q <= pend_pc4_d;
    end
  end

  // Memory shares rst_n; keep the request low while it is held in reset.
  assign imem_req  = rst_n && (state_q == S_REQ);
  assign imem_addr = pc_q;
  assign id_opcode = id_instr[31:26];

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect),
    .load       (load),
    .load_instr (imem_rdata),
    .load_pc4   (pend_pc4_q),
    .out_ready  (id_ready),
    .out_valid  (id_valid),
    .out_instr  (id_instr),
    .out_pc4    (id_pc4)
  );

endmodule
